// File: rtl/pipeline_ctrl_if.sv
// Stall/flush bundle between the pipeline stages and pipeline_ctrl.
// master: stage side (requests out), slave: controller side.
interface pipeline_ctrl_if;
  logic        stallreq_from_id;
  logic        stallreq_from_ex;
  logic        stallreq_from_mem;
  logic [31:0] excepttype_i;
  logic [31:0] cp0_epc_i;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;

  modport master (
    output stallreq_from_id,
    output stallreq_from_ex,
    output stallreq_from_mem,
    output excepttype_i,
    output cp0_epc_i,
    input  stall,
    input  flush,
    input  new_pc
  );

  modport slave (
    input  stallreq_from_id,
    input  stallreq_from_ex,
    input  stallreq_from_mem,
    input  excepttype_i,
    input  cp0_epc_i,
    output stall,
    output flush,
    output new_pc
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the six-stage pipeline, with perf counters.
// Ports: clk, rst (async active-low), ctl (slave bundle), stats outputs.
module pipeline_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
  parameter int          DRAIN_CYCLES = 2,
  parameter int          MAX_STALL    = 1024
) (
  input  logic             clk,
  input  logic             rst,
  pipeline_ctrl_if.slave   ctl,
  output logic [31:0]      stall_cycles,
  output logic [15:0]      flush_count,
  output logic             stall_timeout,
  output logic             busy_drain
);

  localparam logic [31:0] ERET = 32'h0000_000e;
  localparam logic [3:0]  DRN_LOAD = 4'(DRAIN_CYCLES - 1);
  localparam logic [15:0] RUN_MAX  = 16'(MAX_STALL);
  localparam logic [15:0] RUN_HIT  = 16'(MAX_STALL - 1);

  localparam logic [5:0] ST_MEM  = 6'b011111;
  localparam logic [5:0] ST_EX   = 6'b001111;
  localparam logic [5:0] ST_ID   = 6'b000111;
  localparam logic [5:0] ST_NONE = 6'b000000;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  drain_q, drain_d;
  logic [15:0] run_q, run_d;
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [15:0] flush_count_q, flush_count_d;
  logic        timeout_q, timeout_d;
  logic        busy_q, busy_d;

  logic        exc_hit;
  logic        in_run;
  logic        flush_c;
  logic        id_req;
  logic        ex_req;
  logic        mem_req;
  logic        stalled;
  logic [5:0]  stall_c;
  logic [31:0] new_pc_c;

  assign exc_hit = |ctl.excepttype_i;
  assign in_run  = (state_q == RUN);
  assign flush_c = rst & in_run & exc_hit;

  // ID hazards are stale once a flush has emptied the front end.
  assign id_req  = ctl.stallreq_from_id & in_run;
  assign ex_req  = ctl.stallreq_from_ex;
  assign mem_req = ctl.stallreq_from_mem;

  always_comb begin
    stall_c = ST_NONE;
    if (rst && !flush_c) begin
      unique case (1'b1)
        mem_req:
          stall_c = ST_MEM;
        ex_req && !mem_req:
          stall_c = ST_EX;
        id_req && !ex_req && !mem_req:
          stall_c = ST_ID;
        default:
          stall_c = ST_NONE;
      endcase
    end
  end

  always_comb begin
    new_pc_c = 32'h0;
    if (flush_c) begin
      if (ctl.excepttype_i == ERET)
        new_pc_c = ctl.cp0_epc_i;
      else
        new_pc_c = EXC_VECTOR;
    end
  end

  assign stalled = |stall_c;

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    unique case (state_q)
      RUN: begin
        if (exc_hit) begin
          state_d = DRAIN;
          drain_d = DRN_LOAD;
        end
      end
      DRAIN: begin
        if (drain_q == 4'd0)
          state_d = RUN;
        else
          drain_d = drain_q - 4'd1;
      end
      default: begin
        state_d = RUN;
        drain_d = 4'd0;
      end
    endcase
    busy_d = (state_d == DRAIN);
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stalled && stall_cycles_q != 32'hFFFF_FFFF)
      stall_cycles_d = stall_cycles_q + 32'd1;

    flush_count_d = flush_count_q;
    if (flush_c && flush_count_q != 16'hFFFF)
      flush_count_d = flush_count_q + 16'd1;

    run_d = run_q;
    if (!stalled || flush_c)
      run_d = 16'd0;
    else if (run_q != RUN_MAX)
      run_d = run_q + 16'd1;

    // Sets on the MAX_STALL-th consecutive stalled cycle.
    timeout_d = timeout_q | (stalled && run_q == RUN_HIT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= RUN;
      drain_q        <= 4'd0;
      run_q          <= 16'd0;
      stall_cycles_q <= 32'd0;
      flush_count_q  <= 16'd0;
      timeout_q      <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      drain_q        <= drain_d;
      run_q          <= run_d;
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
      timeout_q      <= timeout_d;
      busy_q         <= busy_d;
    end
  end

  assign ctl.stall      = stall_c;
  assign ctl.flush      = flush_c;
  assign ctl.new_pc     = new_pc_c;
  assign stall_cycles   = stall_cycles_q;
  assign flush_count    = flush_count_q;
  assign stall_timeout  = timeout_q;
  assign busy_drain     = busy_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl (MAX_STALL=4, DRAIN_CYCLES=2).
// Table of per-cycle vectors through a scoreboard queue, plus corner cases.
module tb_pipeline_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipeline_ctrl_if bus ();

  logic [31:0] stall_cycles;
  logic [15:0] flush_count;
  logic        stall_timeout;
  logic        busy_drain;

  pipeline_ctrl #(
    .EXC_VECTOR   (32'h0000_0020),
    .DRAIN_CYCLES (2),
    .MAX_STALL    (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ctl           (bus),
    .stall_cycles  (stall_cycles),
    .flush_count   (flush_count),
    .stall_timeout (stall_timeout),
    .busy_drain    (busy_drain)
  );

  typedef struct {
    logic        id;
    logic        ex;
    logic        mem;
    logic [31:0] exc;
    logic [31:0] epc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
    logic        busy;
    logic        tmo;
    logic [31:0] sc;
    logic [15:0] fc;
  } vec_t;

  localparam int NV = 23;
  vec_t tbl [NV];
  vec_t sbq [$];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic id, input logic ex, input logic mem,
    input logic [31:0] exc, input logic [31:0] epc,
    input logic [5:0] st, input logic fl, input logic [31:0] pc,
    input logic bz, input logic tm,
    input logic [31:0] sc, input logic [15:0] fc);
    vec_t v;
    v.id = id; v.ex = ex; v.mem = mem;
    v.exc = exc; v.epc = epc;
    v.stall = st; v.flush = fl; v.pc = pc;
    v.busy = bz; v.tmo = tm; v.sc = sc; v.fc = fc;
    return v;
  endfunction

  task automatic idle();
    bus.stallreq_from_id  = 1'b0;
    bus.stallreq_from_ex  = 1'b0;
    bus.stallreq_from_mem = 1'b0;
    bus.excepttype_i      = 32'h0;
    bus.cp0_epc_i         = 32'h0;
  endtask

  task automatic drive(input vec_t v);
    bus.stallreq_from_id  = v.id;
    bus.stallreq_from_ex  = v.ex;
    bus.stallreq_from_mem = v.mem;
    bus.excepttype_i      = v.exc;
    bus.cp0_epc_i         = v.epc;
    sbq.push_back(v);
  endtask

  task automatic check_row(input int r);
    vec_t e;
    if (sbq.size() == 0) begin
      chk($sformatf("row%0d sbq_empty", r), 32'd0, 32'd1);
      return;
    end
    e = sbq.pop_front();
    chk($sformatf("row%0d stall", r), 32'(bus.stall), 32'(e.stall));
    chk($sformatf("row%0d flush", r), 32'(bus.flush), 32'(e.flush));
    chk($sformatf("row%0d new_pc", r), bus.new_pc, e.pc);
    chk($sformatf("row%0d busy", r), 32'(busy_drain), 32'(e.busy));
    chk($sformatf("row%0d tmo", r), 32'(stall_timeout), 32'(e.tmo));
    chk($sformatf("row%0d scyc", r), stall_cycles, e.sc);
    chk($sformatf("row%0d fcnt", r), 32'(flush_count), 32'(e.fc));
  endtask

  initial begin
    idle();
    // Requests active during reset must not leak to the outputs.
    bus.stallreq_from_mem = 1'b1;
    bus.excepttype_i      = 32'h8;
    @(posedge clk);
    #2;
    chk("rst stall", 32'(bus.stall), 32'd0);
    chk("rst flush", 32'(bus.flush), 32'd0);
    chk("rst new_pc", bus.new_pc, 32'd0);
    chk("rst scyc", stall_cycles, 32'd0);
    chk("rst fcnt", 32'(flush_count), 32'd0);
    chk("rst busy", 32'(busy_drain), 32'd0);
    chk("rst tmo", 32'(stall_timeout), 32'd0);
    idle();
    @(negedge clk);
    rst = 1'b1;

    //          id ex mem exc    epc      stall  fl pc       bz tm sc fc
    tbl[0]  = mk(0, 0, 0, 32'h0, 32'h0,    6'h00, 0, 32'h0,    0, 0, 0, 0);
    tbl[1]  = mk(1, 0, 0, 32'h0, 32'h0,    6'h07, 0, 32'h0,    0, 0, 0, 0);
    tbl[2]  = mk(1, 1, 0, 32'h0, 32'h0,    6'h0f, 0, 32'h0,    0, 0, 1, 0);
    tbl[3]  = mk(1, 0, 0, 32'h0, 32'h0,    6'h07, 0, 32'h0,    0, 0, 2, 0);
    tbl[4]  = mk(0, 0, 0, 32'h0, 32'h0,    6'h00, 0, 32'h0,    0, 0, 3, 0);
    tbl[5]  = mk(0, 0, 0, 32'h8, 32'h0,    6'h00, 1, 32'h20,   0, 0, 3, 0);
    tbl[6]  = mk(0, 0, 0, 32'h0, 32'h0,    6'h00, 0, 32'h0,    1, 0, 3, 1);
    tbl[7]  = mk(0, 0, 0, 32'h0, 32'h0,    6'h00, 0, 32'h0,    1, 0, 3, 1);
    tbl[8]  = mk(0, 0, 0, 32'h0, 32'h0,    6'h00, 0, 32'h0,    0, 0, 3, 1);
    tbl[9]  = mk(0, 0, 0, 32'he, 32'h1234, 6'h00, 1, 32'h1234, 0, 0, 3, 1);
    tbl[10] = mk(1, 0, 0, 32'h8, 32'h0,    6'h00, 0, 32'h0,    1, 0, 3, 2);
    tbl[11] = mk(1, 0, 1, 32'h0, 32'h0,    6'h1f, 0, 32'h0,    1, 0, 3, 2);
    tbl[12] = mk(0, 0, 0, 32'h0, 32'h0,    6'h00, 0, 32'h0,    0, 0, 4, 2);
    tbl[13] = mk(0, 0, 1, 32'h4, 32'h0,    6'h00, 1, 32'h20,   0, 0, 4, 2);
    tbl[14] = mk(0, 0, 0, 32'h0, 32'h0,    6'h00, 0, 32'h0,    1, 0, 4, 3);
    tbl[15] = mk(0, 0, 0, 32'h0, 32'h0,    6'h00, 0, 32'h0,    1, 0, 4, 3);
    tbl[16] = mk(0, 0, 0, 32'h0, 32'h0,    6'h00, 0, 32'h0,    0, 0, 4, 3);
    tbl[17] = mk(0, 1, 0, 32'h0, 32'h0,    6'h0f, 0, 32'h0,    0, 0, 4, 3);
    tbl[18] = mk(0, 1, 0, 32'h0, 32'h0,    6'h0f, 0, 32'h0,    0, 0, 5, 3);
    tbl[19] = mk(0, 1, 0, 32'h0, 32'h0,    6'h0f, 0, 32'h0,    0, 0, 6, 3);
    tbl[20] = mk(0, 1, 0, 32'h0, 32'h0,    6'h0f, 0, 32'h0,    0, 0, 7, 3);
    tbl[21] = mk(0, 1, 0, 32'h0, 32'h0,    6'h0f, 0, 32'h0,    0, 1, 8, 3);
    tbl[22] = mk(0, 0, 0, 32'h0, 32'h0,    6'h00, 0, 32'h0,    0, 1, 9, 3);

    for (int r = 0; r < NV; r++) begin
      @(posedge clk);
      #1;
      drive(tbl[r]);
      #4;
      check_row(r);
    end

    // Async reset in the middle of DRAIN.
    @(posedge clk);
    #1;
    idle();
    bus.excepttype_i = 32'h8;
    #4;
    chk("drn flush", 32'(bus.flush), 32'd1);
    @(posedge clk);
    #1;
    idle();
    #2;
    chk("drn busy_pre", 32'(busy_drain), 32'd1);
    rst = 1'b0;
    #1;
    chk("drn busy_rst", 32'(busy_drain), 32'd0);
    chk("drn scyc_rst", stall_cycles, 32'd0);
    chk("drn fcnt_rst", 32'(flush_count), 32'd0);
    chk("drn tmo_rst", 32'(stall_timeout), 32'd0);
    chk("drn stall_rst", 32'(bus.stall), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // A 3-cycle stall after reset stays below the timeout.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      idle();
      bus.stallreq_from_ex = 1'b1;
      #4;
      chk($sformatf("short%0d stall", i), 32'(bus.stall), 32'h0f);
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      idle();
      #4;
      chk($sformatf("short_end%0d tmo", i), 32'(stall_timeout), 32'd0);
      chk($sformatf("short_end%0d scyc", i), stall_cycles, 32'd3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
